// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller: opcodes, FSM states
// and the absolute jump-target table.
package fetch_pkg;

    localparam logic [2:0] OP_HALT = 3'b111;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_BEZ  = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INIT   = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } state_e;

    // Entry 0 is the rightmost element; edit per program image.
    localparam logic [7:0][15:0] BRANCH_TABLE = {
        16'hFFF0, 16'h0200, 16'h0100, 16'h0080,
        16'h0040, 16'h0020, 16'h0010, 16'h0000
    };

    function automatic logic [15:0] lut_read(input logic [2:0] idx);
        return BRANCH_TABLE[idx];
    endfunction

endpackage

// File: rtl/fetch_ctrl_branch_lut.sv
// Absolute jump-target lookup: 3-bit JMP index to a full PC value.
module branch_lut
    import fetch_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic [2:0]      i_idx,
    output logic [PC_W-1:0] o_target
);

    assign o_target = PC_W'(lut_read(i_idx));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-side sequencer driving the PC block: start-up clear, run-time branch
// decode, normal halt and a run-cycle watchdog.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          PC_W        = 16,
    parameter int          INIT_CYCLES = 2,
    parameter logic [15:0] MAX_CYCLES  = 16'hFFFF
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            Start,
    input  logic [8:0]      Instr,
    input  logic [PC_W-1:0] PC,
    input  logic            ALU_zero,
    output logic [1:0]      Init,
    output logic            Halt,
    output logic            Branch_abs,
    output logic            Branch_rel_en,
    output logic [PC_W-1:0] Target,
    output logic            Done,
    output logic            Error
);

    localparam logic [3:0] INIT_LOAD = 4'(INIT_CYCLES - 1);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [3:0]      r_init_cnt;
    logic [3:0]      w_init_cnt_nxt;
    logic [15:0]     r_cycle_cnt;
    logic [15:0]     w_cycle_cnt_nxt;
    logic            r_done;
    logic            w_done_nxt;
    logic            r_error;
    logic            w_error_nxt;
    logic [2:0]      w_opcode;
    logic            w_watchdog;
    logic [PC_W-1:0] w_offset;
    logic [PC_W-1:0] w_lut_target;
    logic            w_unused;

    // The zero flag is consumed by the PC block, not here.
    assign w_unused   = ALU_zero;
    assign w_opcode   = Instr[8:6];
    assign w_watchdog = (r_cycle_cnt == (MAX_CYCLES - 16'd1));
    assign w_offset   = {{(PC_W-6){Instr[5]}}, Instr[5:0]};

    branch_lut #(.PC_W(PC_W)) u_branch_lut (
        .i_idx    (Instr[2:0]),
        .o_target (w_lut_target)
    );

    // State, counters and status flags
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= IDLE;
            r_init_cnt  <= 4'd0;
            r_cycle_cnt <= 16'd0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_cnt  <= w_init_cnt_nxt;
            r_cycle_cnt <= w_cycle_cnt_nxt;
            r_done      <= w_done_nxt;
            r_error     <= w_error_nxt;
        end
    end

    // Next-state and PC-control decode
    always_comb begin
        w_state_nxt     = r_state;
        w_init_cnt_nxt  = r_init_cnt;
        w_cycle_cnt_nxt = r_cycle_cnt;
        w_done_nxt      = r_done;
        w_error_nxt     = r_error;
        Init            = 2'b01;
        Halt            = 1'b1;
        Branch_abs      = 1'b0;
        Branch_rel_en   = 1'b0;
        Target          = '0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_state_nxt    = INIT;
                    w_init_cnt_nxt = INIT_LOAD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            INIT: begin
                Halt = 1'b0;
                if (r_init_cnt == 4'd0) begin
                    w_state_nxt     = RUN;
                    w_cycle_cnt_nxt = 16'd0;
                end else begin
                    w_init_cnt_nxt = r_init_cnt - 4'd1;
                end
            end
            RUN: begin
                Init            = 2'b00;
                Halt            = 1'b0;
                w_cycle_cnt_nxt = r_cycle_cnt + 16'd1;
                case (w_opcode)
                    OP_JMP: begin
                        Branch_abs = 1'b1;
                        Target     = w_lut_target;
                    end
                    OP_BEZ: begin
                        Branch_rel_en = 1'b1;
                        Target        = PC + w_offset;
                    end
                    OP_HALT: begin
                        Halt = 1'b1;
                    end
                    default: begin
                        Target = '0;
                    end
                endcase
                // A halt instruction wins over a coincident watchdog expiry.
                if (w_opcode == OP_HALT) begin
                    w_state_nxt = HALTED;
                    w_done_nxt  = 1'b1;
                    w_error_nxt = 1'b0;
                end else if (w_watchdog) begin
                    Halt        = 1'b1;
                    w_state_nxt = HALTED;
                    w_done_nxt  = 1'b1;
                    w_error_nxt = 1'b1;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            HALTED: begin
                Init = 2'b00;
                if (Start) begin
                    w_state_nxt    = INIT;
                    w_init_cnt_nxt = INIT_LOAD;
                    w_done_nxt     = 1'b0;
                    w_error_nxt    = 1'b0;
                end else begin
                    w_state_nxt = HALTED;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign Done  = r_done;
    assign Error = r_error;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed walk through start-up, branches,
// halt and watchdog, then randomized traffic against a behavioural model.
module tb_fetch_ctrl;

    localparam int PC_W        = 16;
    localparam int INIT_CYCLES = 2;
    localparam int MAX_CYC     = 8;

    localparam int M_IDLE = 0;
    localparam int M_INIT = 1;
    localparam int M_RUN  = 2;
    localparam int M_HALT = 3;

    logic            CLK = 1'b0;
    logic            RESET_N;
    logic            Start;
    logic [8:0]      Instr;
    logic [PC_W-1:0] PC;
    logic            ALU_zero;
    logic [1:0]      Init;
    logic            Halt;
    logic            Branch_abs;
    logic            Branch_rel_en;
    logic [PC_W-1:0] Target;
    logic            Done;
    logic            Error;

    int n_cmp = 0;
    int n_bad = 0;

    int m_mode;
    int m_init_left;
    int m_runs;
    bit m_done;
    bit m_err;

    logic [15:0] lut_m [8] = '{16'h0000, 16'h0010, 16'h0020, 16'h0040,
                               16'h0080, 16'h0100, 16'h0200, 16'hFFF0};

    fetch_ctrl #(
        .PC_W        (PC_W),
        .INIT_CYCLES (INIT_CYCLES),
        .MAX_CYCLES  (16'(MAX_CYC))
    ) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .Start         (Start),
        .Instr         (Instr),
        .PC            (PC),
        .ALU_zero      (ALU_zero),
        .Init          (Init),
        .Halt          (Halt),
        .Branch_abs    (Branch_abs),
        .Branch_rel_en (Branch_rel_en),
        .Target        (Target),
        .Done          (Done),
        .Error         (Error)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode      = M_IDLE;
        m_init_left = 0;
        m_runs      = 0;
        m_done      = 1'b0;
        m_err       = 1'b0;
    endtask

    task automatic check_outputs();
        int          op;
        int          off;
        logic [1:0]  e_init;
        logic        e_halt;
        logic        e_babs;
        logic        e_brel;
        logic [15:0] e_tgt;
        op     = int'(Instr[8:6]);
        off    = Instr[5] ? int'(Instr[5:0]) - 64 : int'(Instr[5:0]);
        e_init = (m_mode == M_IDLE || m_mode == M_INIT) ? 2'b01 : 2'b00;
        e_babs = (m_mode == M_RUN) && (op == 6);
        e_brel = (m_mode == M_RUN) && (op == 5);
        if (m_mode == M_RUN)
            e_halt = (op == 7) || (m_runs == MAX_CYC - 1);
        else
            e_halt = (m_mode != M_INIT);
        if (e_babs)      e_tgt = lut_m[Instr[2:0]];
        else if (e_brel) e_tgt = 16'(int'(PC) + off);
        else             e_tgt = 16'h0000;
        chk("init", 32'(Init), 32'(e_init));
        chk("halt", 32'(Halt), 32'(e_halt));
        chk("branch_abs", 32'(Branch_abs), 32'(e_babs));
        chk("branch_rel_en", 32'(Branch_rel_en), 32'(e_brel));
        chk("target", 32'(Target), 32'(e_tgt));
        chk("done", 32'(Done), 32'(m_done));
        chk("error", 32'(Error), 32'(m_err));
    endtask

    task automatic model_clock();
        case (m_mode)
            M_IDLE: if (Start) begin m_mode = M_INIT; m_init_left = INIT_CYCLES; end
            M_INIT: begin
                m_init_left--;
                if (m_init_left == 0) begin m_mode = M_RUN; m_runs = 0; end
            end
            M_RUN: begin
                if (Instr[8:6] == 3'b111) begin
                    m_mode = M_HALT; m_done = 1'b1; m_err = 1'b0;
                end else if (m_runs == MAX_CYC - 1) begin
                    m_mode = M_HALT; m_done = 1'b1; m_err = 1'b1;
                end else begin
                    m_runs++;
                end
            end
            default: if (Start) begin
                m_mode = M_INIT; m_init_left = INIT_CYCLES; m_done = 1'b0; m_err = 1'b0;
            end
        endcase
    endtask

    task automatic drive_and_check(input logic st, input logic [8:0] ins, input logic [15:0] pc);
        @(negedge CLK);
        Start    = st;
        Instr    = ins;
        PC       = pc;
        ALU_zero = 1'($urandom % 2);
        #1;
        check_outputs();
    endtask

    task automatic tick();
        @(posedge CLK);
        model_clock();
    endtask

    task automatic cyc(input logic st, input logic [8:0] ins, input logic [15:0] pc);
        drive_and_check(st, ins, pc);
        tick();
    endtask

    function automatic logic [8:0] rand_nop();
        logic [2:0] op;
        op = 3'($urandom % 5);
        return {op, 6'($urandom)};
    endfunction

    task automatic reset_mid_cycle();
        #2 RESET_N = 1'b0;
        #1;
        chk("rst_init", 32'(Init), 32'h1);
        chk("rst_halt", 32'(Halt), 32'h1);
        chk("rst_done", 32'(Done), 32'h0);
        chk("rst_error", 32'(Error), 32'h0);
        model_reset();
        @(posedge CLK);
        #2 RESET_N = 1'b1;
    endtask

    initial begin
        RESET_N  = 1'b0;
        Start    = 1'b0;
        Instr    = 9'd0;
        PC       = 16'd0;
        ALU_zero = 1'b0;
        model_reset();
        #3;
        check_outputs();
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);

        cyc(1'b0, 9'd0, 16'd0);
        cyc(1'b0, 9'd0, 16'd0);
        cyc(1'b1, 9'd0, 16'd0);
        drive_and_check(1'b0, 9'd0, 16'd0);
        chk("init_c1", 32'(Init), 32'h1);
        tick();
        drive_and_check(1'b0, 9'd0, 16'd0);
        chk("init_c2", 32'(Init), 32'h1);
        tick();

        drive_and_check(1'b0, 9'b101_111100, 16'd10);
        chk("bez_tgt", 32'(Target), 32'h6);
        chk("bez_en", 32'(Branch_rel_en), 32'h1);
        chk("run_init", 32'(Init), 32'h0);
        tick();
        drive_and_check(1'b0, 9'b101_111111, 16'd0);
        chk("bez_wrap", 32'(Target), 32'hFFFF);
        tick();
        drive_and_check(1'b0, 9'b110_000011, 16'd7);
        chk("jmp_tgt", 32'(Target), 32'h40);
        chk("jmp_abs", 32'(Branch_abs), 32'h1);
        tick();
        drive_and_check(1'b0, 9'b111_000000, 16'd8);
        chk("halt_now", 32'(Halt), 32'h1);
        tick();
        drive_and_check(1'b0, 9'd0, 16'd8);
        chk("halt_done", 32'(Done), 32'h1);
        chk("halt_noerr", 32'(Error), 32'h0);
        tick();
        cyc(1'b1, 9'd0, 16'd8);
        drive_and_check(1'b0, 9'd0, 16'd0);
        chk("restart_done", 32'(Done), 32'h0);
        tick();
        cyc(1'b0, 9'd0, 16'd0);

        for (int i = 0; i < MAX_CYC - 1; i++) cyc(1'b0, rand_nop(), 16'(i));
        drive_and_check(1'b0, rand_nop(), 16'd7);
        chk("wd_halt", 32'(Halt), 32'h1);
        tick();
        drive_and_check(1'b1, 9'd0, 16'd7);
        chk("wd_done", 32'(Done), 32'h1);
        chk("wd_error", 32'(Error), 32'h1);
        tick();
        cyc(1'b0, 9'd0, 16'd0);
        cyc(1'b0, 9'd0, 16'd0);

        for (int i = 0; i < MAX_CYC - 1; i++) cyc(1'b0, rand_nop(), 16'(i));
        cyc(1'b0, 9'b111_010101, 16'd7);
        drive_and_check(1'b1, 9'd0, 16'd7);
        chk("wdh_done", 32'(Done), 32'h1);
        chk("wdh_error", 32'(Error), 32'h0);
        tick();
        cyc(1'b0, 9'd0, 16'd0);
        cyc(1'b0, 9'd0, 16'd0);

        cyc(1'b1, 9'd0, 16'd0);
        drive_and_check(1'b1, 9'd0, 16'd1);
        chk("start_ign", 32'(Init), 32'h0);
        reset_mid_cycle();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 250 == 0) begin
                drive_and_check(1'b0, 9'($urandom), 16'($urandom));
                reset_mid_cycle();
            end else begin
                cyc(1'($urandom % 6 == 0), 9'($urandom), 16'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Control-side initiator for the instruction-fetch program counter. It drives the PC block's Init, Halt, Branch_abs, Branch_rel_en and Target inputs.
- Consumes the current PC and the 9-bit instruction returned by instruction ROM.
- Sequences start-up (Init hold), normal run, branch requests and halt. Reports Done/Error to the testbench or top level.
- Sits between the decode stage and the PC block in the basic processor.

Parameters:
- PC_W, 16, width of PC and Target.
- INIT_CYCLES, 2, number of cycles Init is held after Start (1..15).
- MAX_CYCLES, 16'hFFFF, run-cycle watchdog limit; reaching it forces halt with Error.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RESET_N  in  1  asynchronous active-low reset.
- Start  in  1  level/pulse request to (re)start program; sampled in IDLE and HALTED only.
- Instr  in  9  instruction at current PC (combinational ROM output).
- PC  in  PC_W  current program counter from PC block.
- ALU_zero  in  1  ALU zero flag; passed through for use by the PC block.
- Init  out  2  PC clear request; 2'b01 = clear, 2'b00 = run.
- Halt  out  1  freeze PC.
- Branch_abs  out  1  unconditional absolute jump request.
- Branch_rel_en  out  1  conditional relative jump enable (PC block ANDs with ALU_zero).
- Target  out  PC_W  jump destination, already resolved to an absolute PC.
- Done  out  1  registered; program halted normally or by watchdog.
- Error  out  1  registered; watchdog expired.

Behaviour:
- Opcode = Instr[8:6]: OP_HALT=3'b111, OP_JMP=3'b110, OP_BEZ=3'b101; all others are non-control.
- States: IDLE, INIT, RUN, HALTED.
- Reset (async, any state): state=IDLE, Init=2'b01, Halt=1, Done=0, Error=0, init counter=0, cycle counter=0.
- IDLE: Init=2'b01, Halt=1. If Start, go to INIT and load init counter with INIT_CYCLES-1.
- INIT: Init=2'b01, Halt=0. The counter decrements each cycle; at 0, go to RUN and clear the cycle counter. Init is therefore high for exactly INIT_CYCLES cycles after the Start edge.
- RUN: Init=2'b00. Decode is combinational from Instr in the same cycle:
  - OP_JMP: Branch_abs=1, Target=lut[Instr[2:0]].
  - OP_BEZ: Branch_rel_en=1, Target=PC + sign_extend(Instr[5:0]), computed modulo 2^PC_W. Wrap-around is allowed and not flagged.
  - OP_HALT: Halt=1 in the same cycle so the PC freezes on the halt instruction; next state is HALTED and Done=1 from the next cycle.
  - Otherwise: all branch outputs 0 and Target=0.
- Branch_abs and Branch_rel_en are never asserted together; they are 0 in every state other than RUN.
- Watchdog: the cycle counter increments every RUN cycle. When it equals MAX_CYCLES-1 and Instr is not OP_HALT, Halt=1 that cycle, go to HALTED with Done=1 and Error=1.
  - If OP_HALT and the watchdog coincide, the halt is treated as normal: Error=0.
- HALTED: Halt=1, Init=2'b00; Done and Error hold. If Start, go to INIT, clear Done and Error on that edge, and reload the init counter.
- Start is ignored in INIT and RUN.
- Reset mid-RUN returns immediately to IDLE outputs. Deassertion of RESET_N takes effect on the next CLK edge.
- ALU_zero is not used internally.

Decomposition:
- Package fetch_pkg: opcode localparams (OP_HALT, OP_JMP, OP_BEZ), state enum type (IDLE/INIT/RUN/HALTED), and the 8-entry absolute-target constant table.
- Sub-module branch_lut: combinational 3-bit index to PC_W target, read from the fetch_pkg table. This keeps the table replaceable per program.

Test Plan:
- Reset, then Start pulse at cycle 3 with INIT_CYCLES=2: Init=2'b01 for cycles 4-5, RUN at cycle 6, Halt=0, Done=0.
- RUN with PC=10 and Instr=9'b101_111100 (BEZ, offset -4): Branch_rel_en=1, Target=6, Branch_abs=0. PC=0 with offset -1 gives Target=16'hFFFF.
- RUN with Instr=9'b110_000011 and lut[3]=16'h0040: Branch_abs=1, Target=16'h0040. Same cycle OP_HALT: Halt=1; next cycle Done=1, Error=0. Start then gives Done=0 and INIT.
- MAX_CYCLES=8, program with no halt: Halt=1 on the 8th RUN cycle, then Done=1 and Error=1. Repeat with OP_HALT on exactly the 8th cycle: Error=0.
- Assert RESET_N=0 mid-RUN between clock edges: outputs immediately Init=2'b01, Halt=1, Done=0. Start during RUN is ignored (state stays RUN).
